// File: rtl/dmem_pkg.sv
// Shared types and constants for the main data memory.
// The optional DMEM_STATS_EN build (access counters) is handled in data_memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int DMEM_LATENCY_DEF = 5;
  localparam int DMEM_BLOCK_BYTES = 4;
  localparam int DMEM_CNT_W       = 4;

endpackage

// File: rtl/dmem_storage.sv
// Block storage array with one synchronous write port and one synchronous read port.
// The read register clears on reset; the array contents never do.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = DMEM_BLOCK_BYTES * 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on the array so it maps onto RAM and survives reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// Main data memory behind the data cache: IDLE/BUSY/DONE FSM modelling multi-cycle latency.
// Define DMEM_STATS_EN to add saturating read_count/write_count outputs.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = DMEM_BLOCK_BYTES * 8,
  parameter int LATENCY = DMEM_LATENCY_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait,
`ifdef DMEM_STATS_EN
  output logic [15:0]       read_count,
  output logic [15:0]       write_count,
`endif
  output dmem_state_e       debug_state
);

  // Handshake: the cache holds read or write (never both) and waits while
  // busywait is high; the cycle busywait drops (DONE) the access has completed.
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_e           state;
  dmem_state_e           next_state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic                  op_write;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  req;
  logic                  commit;

  assign req         = read ^ write;
  assign commit      = (state == BUSY) && (cnt == '0);
  assign debug_state = state;

  always_comb begin
    next_state = state;
    busywait   = 1'b0;
    case (state)
      IDLE: begin
        busywait = req;
        if (req) next_state = BUSY;
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (reset) busywait = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= next_state;
      // Requests are captured only in IDLE; later input changes are ignored.
      if (state == IDLE && req) begin
        op_write <= write;
        addr_q   <= address;
        wdata_q  <= writedata;
        cnt      <= CNT_LOAD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - DMEM_CNT_W'(1);
      end
    end
  end

  dmem_storage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_storage (
    .clock (clock),
    .reset (reset),
    .we    (commit && op_write && !reset),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (commit && !op_write),
    .raddr (addr_q),
    .rdata (readdata)
  );

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (commit) begin
      if (op_write && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      if (!op_write && read_count != 16'hFFFF) read_count <= read_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: driver tasks push expected readdata at each access,
// a monitor pops and compares whenever busywait falls (DONE).
module tb_data_memory;
  import dmem_pkg::*;

  localparam int LAT = DMEM_LATENCY_DEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  dmem_state_e debug_state;
`ifdef DMEM_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  data_memory dut (
    .clock       (clock),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .busywait    (busywait),
`ifdef DMEM_STATS_EN
    .read_count  (read_count),
    .write_count (write_count),
`endif
    .debug_state (debug_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (cycles) @(negedge clock);
    #1 check("reset_busywait", 32'(busywait), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_state", 32'(debug_state), 32'(IDLE));
`ifdef DMEM_STATS_EN
    check("reset_read_count", 32'(read_count), 32'h0);
    check("reset_write_count", 32'(write_count), 32'h0);
`endif
    reset   = 1'b0;
    last_rd = 32'h0;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic rd, input logic [5:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input int drop_at, input string name);
    int n;
    @(negedge clock);
    read      = rd;
    write     = !rd;
    address   = addr;
    writedata = data;
    if (rd) last_rd = exp_rd;
    exp_q.push_back(last_rd);
    #1 check({name, "_busy_same_cycle"}, 32'(busywait), 32'h1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == drop_at) begin
        read      = 1'b0;
        write     = 1'b0;
        address   = addr + 6'd1;
        writedata = ~data;
      end
    end while (busywait && n < 40);
    check({name, "_latency"}, 32'(n), 32'(LAT + 1));
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_rd, input string name);
    issue(1'b1, addr, 32'h0, exp_rd, 0, name);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input int drop_at,
                          input string name);
    issue(1'b0, addr, data, 32'h0, drop_at, name);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && prev_busy && !busywait) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got completion with readdata %h, expected none", readdata);
        end else begin
          check("done_readdata", readdata, exp_q.pop_front());
        end
      end
      prev_busy = busywait && !reset;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = 6'h0;
    writedata = 32'h0;
    do_reset(2);

    // preload, then reset to show contents survive
    do_write(6'h05, 32'hDEADBEEF, 0, "preload_05");
    do_reset(1);
    do_read(6'h05, 32'hDEADBEEF, "read_05");

    do_write(6'h3F, 32'h01234567, 0, "write_3f");
    do_read(6'h3F, 32'h01234567, "read_3f");

    // inputs dropped/changed mid-BUSY must not affect the latched write
    do_write(6'h11, 32'h0BADF00D, 0, "preload_11");
    do_write(6'h10, 32'hA5A5A5A5, 2, "write_10_drop");
    do_read(6'h10, 32'hA5A5A5A5, "read_10");
    do_read(6'h11, 32'h0BADF00D, "read_11");

    // read and write together is ignored
    @(negedge clock);
    read      = 1'b1;
    write     = 1'b1;
    address   = 6'h3F;
    writedata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      #1 check("both_busywait", 32'(busywait), 32'h0);
      check("both_state", 32'(debug_state), 32'(IDLE));
      @(negedge clock);
    end
    read  = 1'b0;
    write = 1'b0;
    do_read(6'h3F, 32'h01234567, "read_3f_after_both");

    // reset in the middle of a write aborts it
    do_write(6'h08, 32'h11112222, 0, "preload_08");
    @(negedge clock);
    write     = 1'b1;
    address   = 6'h08;
    writedata = 32'hCAFEF00D;
    #1 check("abort_busy_same_cycle", 32'(busywait), 32'h1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    write = 1'b0;
    #1 check("abort_busy_in_reset", 32'(busywait), 32'h0);
    @(negedge clock);
    #1 check("abort_busy_next", 32'(busywait), 32'h0);
    check("abort_readdata", readdata, 32'h0);
    reset   = 1'b0;
    last_rd = 32'h0;
    @(negedge clock);
    #1 check("abort_state", 32'(debug_state), 32'(IDLE));
    check("abort_busy_after", 32'(busywait), 32'h0);
    do_read(6'h08, 32'h11112222, "read_08_after_abort");

    // access mix: 3 reads, 2 writes since reset
    do_reset(1);
    do_read(6'h05, 32'hDEADBEEF, "mix_read_05");
    do_write(6'h20, 32'h12345678, 0, "mix_write_20");
    do_read(6'h20, 32'h12345678, "mix_read_20");
    do_write(6'h21, 32'h87654321, 0, "mix_write_21");
    do_read(6'h21, 32'h87654321, "mix_read_21");
`ifdef DMEM_STATS_EN
    #1 check("stats_read_count", 32'(read_count), 32'd3);
    check("stats_write_count", 32'(write_count), 32'd2);
`endif
    do_reset(1);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
